zxuno_uart_tx_arbiter: RTL and testbench
========================================

// Module: zxuno_uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between two byte sources: req0 (ZX-UNO
//  UARTDATA register writes) and req1 (secondary source, e.g. boot/debug
//  streamer). Round-robin arbitration. Drives the uart txbegin/txdata pair
//  with its level handshake: txbegin is held until txbusy rises. Includes a
//  start watchdog with a sticky error flag. Sits between the register
//  decoders and the uart instance.
// PARAMETERS
//  START_TIMEOUT   255  clk cycles to wait in START for txbusy=1 before abort (1..65535)
//  FIXED_PRIORITY  0    0 = round-robin; 1 = req0 always wins a tie
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  asynchronous reset, active low
//  req0_valid    in   1  requester 0 has a byte; held until accepted
//  req0_data     in   8  requester 0 byte
//  req0_ready    out  1  requester 0 byte accepted this cycle (valid&ready)
//  req1_valid    in   1  requester 1 has a byte; held until accepted
//  req1_data     in   8  requester 1 byte
//  req1_ready    out  1  requester 1 byte accepted this cycle
//  uart_txdata   out  8  byte to uart; stable from START until back in IDLE
//  uart_txbegin  out  1  uart start request (level)
//  uart_txbusy   in   1  uart transmitter busy
//  busy          out  1  arbiter not IDLE
//  owner         out  1  requester of byte in flight (valid while busy)
//  err_timeout   out  1  sticky: a byte was dropped by the start watchdog
//  err_clear     in   1  clears err_timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, uart_txbegin=0, uart_txdata=0, owner=0,
//   err_timeout=0, cnt=0, last=1 (req0 wins first tie). reqN_ready=0 while
//   rst_n=0.
//  States: IDLE, START, WAIT_DONE.
//  IDLE: reqN_ready is combinational: state==IDLE && !uart_txbusy && reqN_valid
//   && sel==N. At most one ready is high per cycle.
//   sel: only one valid -> that one. Both valid -> FIXED_PRIORITY ? 0 : !last.
//   On transfer: latch data into uart_txdata, owner<=sel, last<=sel, cnt<=0,
//   uart_txbegin<=1, go to START. If uart_txbusy=1 in IDLE (uart busy for
//   another reason), nothing is accepted.
//  START: uart_txbegin=1. If uart_txbusy=1: txbegin<=0, go to WAIT_DONE.
//   Else if cnt==START_TIMEOUT-1: txbegin<=0, err_timeout<=1, go to IDLE (byte
//   dropped, no retry). Else cnt<=cnt+1 (16-bit, never wraps).
//  WAIT_DONE: txbegin=0. When uart_txbusy=0, go to IDLE. A new byte can be
//   accepted in the first IDLE cycle.
//  Latency: valid seen in IDLE at cycle N -> ready in cycle N -> txbegin=1
//   from N+1 -> earliest txbegin fall at the cycle after txbusy is seen high.
//  err_clear=1 clears err_timeout. A same-cycle set wins over clear.
//  valid deasserted before acceptance: no effect. Data is sampled only on
//   transfer. uart_txdata holds its last value in IDLE.
//  busy = (state!=IDLE).
// TESTING
//  Single byte: req0_valid, data=8'hA5, uart model raises txbusy 2 clk after
//   txbegin -> req0_ready for 1 cycle; txdata=A5; txbegin high 3 cycles; busy
//   falls 1 cycle after txbusy falls.
//  Tie round-robin: both valid continuously (req0=8'h11, req1=8'h22), 4 bytes
//   -> order 11,22,11,22 with FIXED_PRIORITY=0; 11,11,11,11 with =1.
//  Watchdog: START_TIMEOUT=8, txbusy stuck 0 -> txbegin high exactly 8 cycles,
//   then err_timeout=1, IDLE. err_clear pulse -> 0. Clear in the same cycle as
//   a new timeout -> stays 1.
//  Busy uart: txbusy=1 while IDLE with req1_valid -> no ready until txbusy=0.
//   Then accepted that same cycle.
//  Async reset in WAIT_DONE and in START -> all outputs at reset values
//   immediately, without waiting for a clk edge. Post-reset tie -> req0 served first.

Source files
------------

// File: rtl/zxuno_uart_tx_arbiter.sv
// Two-source arbiter in front of the ZX-UNO UART transmitter. It selects a
// byte, then drives the txbegin/txdata level handshake with a start watchdog.
module zxuno_uart_tx_arbiter #(
    parameter int unsigned START_TIMEOUT  = 255,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] uart_txdata,
    output logic       uart_txbegin,
    input  logic       uart_txbusy,
    output logic       busy,
    output logic       owner,
    output logic       err_timeout,
    input  logic       err_clear
);

    // state     | meaning
    // IDLE      | waiting for a byte; readies may be granted
    // START     | txbegin held, waiting for txbusy (watchdog running)
    // WAIT_DONE | uart transmitting; waiting for txbusy to drop
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(START_TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        last;
    logic        sel;
    logic        grant_ok;
    logic        accept;

    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
            sel = FIXED_PRIORITY ? 1'b0 : ~last;
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    // rst_n gating keeps both readies low for the whole reset period
    assign grant_ok   = rst_n && (state == IDLE) && !uart_txbusy;
    assign req0_ready = grant_ok && req0_valid && !sel;
    assign req1_ready = grant_ok && req1_valid && sel;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            uart_txbegin <= 1'b0;
            uart_txdata  <= 8'h00;
            owner        <= 1'b0;
            err_timeout  <= 1'b0;
            cnt          <= 16'h0000;
            last         <= 1'b1;
        end else begin
            // clear first so a same-cycle watchdog set below takes priority
            if (err_clear) begin
                err_timeout <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        uart_txdata  <= sel ? req1_data : req0_data;
                        owner        <= sel;
                        last         <= sel;
                        cnt          <= 16'h0000;
                        uart_txbegin <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    if (uart_txbusy) begin
                        uart_txbegin <= 1'b0;
                        state        <= WAIT_DONE;
                    end else if (cnt == CNT_LAST) begin
                        uart_txbegin <= 1'b0;
                        err_timeout  <= 1'b1;
                        state        <= IDLE;
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_txbusy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    uart_txbegin <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zxuno_uart_tx_arbiter.sv
// Bench for zxuno_uart_tx_arbiter: a round-robin and a fixed-priority instance,
// each with a small uart model; bytes are scoreboarded at every txbegin rise.
module tb_zxuno_uart_tx_arbiter;

    logic       clk;
    logic       rst_n;
    logic       r0v [2];
    logic       r1v [2];
    logic       clr [2];
    logic [7:0] r0d [2];
    logic [7:0] r1d [2];
    logic       r0r [2];
    logic       r1r [2];
    logic [7:0] txd [2];
    logic       txb [2];
    logic       txbusy [2];
    logic       bsy [2];
    logic       own [2];
    logic       err [2];
    logic       stuck [2];
    logic       hold [2];
    logic       mbusy [2];
    logic [1:0] bc [2];
    logic [2:0] left [2];
    logic       pb [2];

    int n_checks;
    int n_fail;
    bit [8:0] q0 [$];
    bit [8:0] q1 [$];

    zxuno_uart_tx_arbiter #(.START_TIMEOUT(8), .FIXED_PRIORITY(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v[0]), .req0_data(r0d[0]), .req0_ready(r0r[0]),
        .req1_valid(r1v[0]), .req1_data(r1d[0]), .req1_ready(r1r[0]),
        .uart_txdata(txd[0]), .uart_txbegin(txb[0]), .uart_txbusy(txbusy[0]),
        .busy(bsy[0]), .owner(own[0]), .err_timeout(err[0]), .err_clear(clr[0])
    );

    zxuno_uart_tx_arbiter #(.START_TIMEOUT(8), .FIXED_PRIORITY(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v[1]), .req0_data(r0d[1]), .req0_ready(r0r[1]),
        .req1_valid(r1v[1]), .req1_data(r1d[1]), .req1_ready(r1r[1]),
        .uart_txdata(txd[1]), .uart_txbegin(txb[1]), .uart_txbusy(txbusy[1]),
        .busy(bsy[1]), .owner(own[1]), .err_timeout(err[1]), .err_clear(clr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 2; i++) txbusy[i] = mbusy[i] | hold[i];
    end

    // uart model: txbusy rises 2 clocks after txbegin is seen, stays 5 clocks
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mbusy[i] <= 1'b0;
                bc[i]    <= 2'd0;
                left[i]  <= 3'd0;
            end else if (!mbusy[i]) begin
                if (txb[i] && !stuck[i]) begin
                    if (bc[i] == 2'd1) begin
                        mbusy[i] <= 1'b1;
                        left[i]  <= 3'd4;
                        bc[i]    <= 2'd0;
                    end else begin
                        bc[i] <= bc[i] + 2'd1;
                    end
                end else begin
                    bc[i] <= 2'd0;
                end
            end else if (left[i] == 3'd0) begin
                mbusy[i] <= 1'b0;
            end else begin
                left[i] <= left[i] - 3'd1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard monitor: every txbegin rise must match the next queued {owner,data}
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (txb[i] === 1'b1 && pb[i] !== 1'b1) begin
                bit [8:0] e;
                bit       have;
                have = 1'b0;
                e    = 9'h000;
                if (i == 0 && q0.size() > 0) begin
                    e = q0.pop_front(); have = 1'b1;
                end else if (i == 1 && q1.size() > 0) begin
                    e = q1.pop_front(); have = 1'b1;
                end
                if (have) begin
                    chk($sformatf("sb_byte[%0d]", i), 32'({own[i], txd[i]}), 32'(e));
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected[%0d]: got %03h with no byte expected", i, {own[i], txd[i]});
                end
            end
            pb[i] = txb[i];
        end
    end

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (bsy[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bsy[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout[%0d]: busy got 1 expected 0", i);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready0"}, 32'(r0r[0]), 32'd0);
        chk({tag, "_ready1"}, 32'(r1r[0]), 32'd0);
        chk({tag, "_txbegin"}, 32'(txb[0]), 32'd0);
        chk({tag, "_txdata"}, 32'(txd[0]), 32'd0);
        chk({tag, "_busy"}, 32'(bsy[0]), 32'd0);
        chk({tag, "_owner"}, 32'(own[0]), 32'd0);
        chk({tag, "_err"}, 32'(err[0]), 32'd0);
    endtask

    // count txbegin-high cycles; optionally pulse err_clear on the watchdog's firing edge
    task automatic count_begin(input bit clr_on_expire, output int n);
        n = 1;
        while (n < 50) begin
            if (clr_on_expire && n == 8) clr[0] = 1'b1;
            @(negedge clk);
            if (!txb[0]) break;
            n++;
        end
        clr[0] = 1'b0;
    endtask

    initial begin
        int n;
        int acc [2];
        int both_hi;
        int rdy_seen;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 2; i++) begin
            r0v[i] = 0; r1v[i] = 0; clr[i] = 0; r0d[i] = 0; r1d[i] = 0;
            stuck[i] = 0; hold[i] = 0; pb[i] = 0;
        end
        rst_n  = 1'b0;
        r0v[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("por");
        r0v[0] = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);

        // single byte
        r0v[0] = 1'b1; r0d[0] = 8'hA5; q0.push_back({1'b0, 8'hA5});
        #1 chk("single_ready0", 32'(r0r[0]), 32'd1);
        chk("single_ready1", 32'(r1r[0]), 32'd0);
        @(negedge clk);
        chk("single_ready_pulse", 32'(r0r[0]), 32'd0);
        chk("single_busy", 32'(bsy[0]), 32'd1);
        chk("single_txbegin", 32'(txb[0]), 32'd1);
        r0v[0] = 1'b0;
        count_begin(1'b0, n);
        chk("single_begin_cycles", 32'(n), 32'd3);
        n = 0;
        while (txbusy[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("single_busy_after_txbusy_fall", 32'(bsy[0]), 32'd1);
        @(negedge clk);
        chk("single_busy_fall", 32'(bsy[0]), 32'd0);

        // tie: round-robin on dut_rr, fixed priority on dut_fp, from reset
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h22});
        q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h22});
        for (int k = 0; k < 4; k++) q1.push_back({1'b0, 8'h11});
        for (int i = 0; i < 2; i++) begin
            r0v[i] = 1'b1; r0d[i] = 8'h11; r1v[i] = 1'b1; r1d[i] = 8'h22; acc[i] = 0;
        end
        both_hi = 0;
        for (int c = 0; c < 400 && (acc[0] < 4 || acc[1] < 4); c++) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i] < 4) begin
                    if (r0r[i] && r1r[i]) both_hi++;
                    if (r0r[i] || r1r[i]) acc[i]++;
                end
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (acc[i] == 4) begin
                    r0v[i] = 1'b0; r1v[i] = 1'b0;
                end
            end
        end
        chk("tie_rr_count", 32'(acc[0]), 32'd4);
        chk("tie_fp_count", 32'(acc[1]), 32'd4);
        chk("tie_one_ready", 32'(both_hi), 32'd0);
        wait_idle(0);
        wait_idle(1);

        // watchdog with txbusy stuck low
        stuck[0] = 1'b1;
        r0v[0] = 1'b1; r0d[0] = 8'h5A; q0.push_back({1'b0, 8'h5A});
        #1 chk("wd_ready0", 32'(r0r[0]), 32'd1);
        @(negedge clk);
        r0v[0] = 1'b0;
        count_begin(1'b0, n);
        chk("wd_begin_cycles", 32'(n), 32'd8);
        chk("wd_err_set", 32'(err[0]), 32'd1);
        chk("wd_idle", 32'(bsy[0]), 32'd0);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        chk("wd_err_clear", 32'(err[0]), 32'd0);
        r0v[0] = 1'b1; r0d[0] = 8'h5B; q0.push_back({1'b0, 8'h5B});
        @(negedge clk);
        r0v[0] = 1'b0;
        count_begin(1'b1, n);
        chk("wd2_begin_cycles", 32'(n), 32'd8);
        chk("wd_set_beats_clear", 32'(err[0]), 32'd1);
        stuck[0] = 1'b0;
        @(negedge clk);

        // uart busy for another reason while idle
        hold[0] = 1'b1;
        @(negedge clk);
        r1v[0] = 1'b1; r1d[0] = 8'hC3; q0.push_back({1'b1, 8'hC3});
        rdy_seen = 0;
        repeat (5) begin
            #1 if (r1r[0]) rdy_seen++;
            @(negedge clk);
        end
        chk("busyuart_no_ready", 32'(rdy_seen), 32'd0);
        hold[0] = 1'b0;
        #1 chk("busyuart_ready_same_cycle", 32'(r1r[0]), 32'd1);
        @(negedge clk);
        r1v[0] = 1'b0;
        wait_idle(0);

        // async reset in WAIT_DONE
        r1v[0] = 1'b1; r1d[0] = 8'h77; q0.push_back({1'b1, 8'h77});
        @(negedge clk);
        r1v[0] = 1'b0;
        n = 0;
        while ((txb[0] || !bsy[0]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wd_reached", 32'({bsy[0], txb[0], txbusy[0]}), 32'b101);
        #2 rst_n = 1'b0;
        r0v[0] = 1'b1; r0d[0] = 8'h88;
        #1 chk_reset("rst_wait_done");
        @(negedge clk);

        // async reset in START
        rst_n = 1'b1;
        q0.push_back({1'b0, 8'h88});
        #1 chk("rst_start_ready0", 32'(r0r[0]), 32'd1);
        @(negedge clk);
        r0v[0] = 1'b0;
        chk("rst_start_reached", 32'({bsy[0], txb[0]}), 32'b11);
        #2 rst_n = 1'b0;
        r0v[0] = 1'b1; r0d[0] = 8'h11; r1v[0] = 1'b1; r1d[0] = 8'h22;
        #1 chk_reset("rst_start");
        @(negedge clk);

        // tie straight after reset goes to req0
        rst_n = 1'b1;
        q0.push_back({1'b0, 8'h11});
        #1 chk("post_rst_ready0", 32'(r0r[0]), 32'd1);
        chk("post_rst_ready1", 32'(r1r[0]), 32'd0);
        @(negedge clk);
        r0v[0] = 1'b0; r1v[0] = 1'b0;
        wait_idle(0);
        @(negedge clk);

        chk("sb_rr_drained", 32'(q0.size()), 32'd0);
        chk("sb_fp_drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
